// File: rtl/spad_tdc_sequencer_pkg.sv
// Shared types and constants for the SPAD/TDC frame sequencer.
package spad_seq_pkg;

  localparam int RANGE_CYC = 512;  // window length in clk_250M cycles (2048 ns)
  localparam int MAX_HITS  = 3;    // hits accepted before the frame ends early
  localparam int DEAD_CYC  = 4;    // rst_auto high time for pre-clear and re-arm
  localparam int GAP_CYC   = 16;   // idle cycles between frames

  localparam int COARSE_W = $clog2(RANGE_CYC);
  localparam int IDX_W    = 2;
  localparam int INT_W    = 16;
  localparam int CNT_W    = 4;     // wide enough for GAP_CYC-1 and DEAD_CYC-1

  typedef enum logic [2:0] {
    IDLE, CLEAR, START, WINDOW, ARM, REARM, DONE, GAP
  } seq_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]    idx;
    logic [COARSE_W-1:0] coarse;
    logic [INT_W-1:0]    intensity;
  } hit_rec_t;

endpackage

// File: rtl/spad_tdc_sequencer_if.sv
// SPAD/TDC control, hit stream and frame summary bundle.
interface spad_tdc_sequencer_if;
  import spad_seq_pkg::*;

  logic                enable;
  logic                trig;
  logic                time_gate;
  logic [INT_W-1:0]    spad_int;
  logic                tdc_start;
  logic                rst_auto;
  logic                hit_valid;
  logic                hit_ready;
  logic [IDX_W-1:0]    hit_idx;
  logic [COARSE_W-1:0] hit_coarse;
  logic [INT_W-1:0]    hit_int;
  logic                frame_done;
  logic [IDX_W-1:0]    frame_hits;
  logic                frame_ovf;

  // Sequencer side
  modport master (
    input  enable, trig, time_gate, spad_int, hit_ready,
    output tdc_start, rst_auto, hit_valid, hit_idx, hit_coarse, hit_int,
           frame_done, frame_hits, frame_ovf
  );

  // SPAD macro / readout side
  modport slave (
    output enable, trig, time_gate, spad_int, hit_ready,
    input  tdc_start, rst_auto, hit_valid, hit_idx, hit_coarse, hit_int,
           frame_done, frame_hits, frame_ovf
  );

endinterface

// File: rtl/spad_tdc_sequencer_sync2.sv
// Two-flop level synchronizer, clears to 0.
module spad_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture of an asynchronous level into the local clock domain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spad_tdc_sequencer.sv
// Per-frame SPAD/TDC measurement sequencer.
//
//   state  | meaning
//   IDLE   | waiting for enable
//   CLEAR  | SPAD pre-clear, rst_auto high DEAD_CYC cycles
//   START  | tdc_start pulse, frame counters cleared
//   WINDOW | coarse window running, watching for trig edges
//   ARM    | hit taken, waiting for time_gate to close
//   REARM  | rst_auto high DEAD_CYC cycles, then wait for trig to drop
//   DONE   | frame_done pulse with summary
//   GAP    | GAP_CYC idle cycles before the next frame
module spad_tdc_sequencer
  import spad_seq_pkg::*;
(
  input  logic                  clk_250M,
  input  logic                  rst,
  spad_tdc_sequencer_if.master  io_bus
);

  logic                w_trig_s;
  logic                w_gate_s;
  logic                w_hit;
  logic                w_win_end;
  logic                w_take;

  seq_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [COARSE_W-1:0] r_wcnt;
  logic [IDX_W-1:0]    r_hits;
  logic                r_ovf;
  logic                r_trig_d;
  logic                r_tdc_start;
  logic                r_rst_auto;
  logic                r_hit_valid;
  hit_rec_t            r_rec;
  logic                r_frame_done;
  logic [IDX_W-1:0]    r_frame_hits;
  logic                r_frame_ovf;

  spad_sync2 u_sync_trig (
    .i_clk (clk_250M),
    .i_rst (rst),
    .i_d   (io_bus.trig),
    .o_q   (w_trig_s)
  );

  spad_sync2 u_sync_gate (
    .i_clk (clk_250M),
    .i_rst (rst),
    .i_d   (io_bus.time_gate),
    .o_q   (w_gate_s)
  );

  assign w_hit     = w_trig_s & ~r_trig_d;
  assign w_win_end = (r_wcnt == COARSE_W'(RANGE_CYC - 1));
  assign w_take    = r_hit_valid & io_bus.hit_ready;

  // Delayed copy of synchronized trig for rising-edge detection
  always_ff @(posedge clk_250M) begin
    if (rst) r_trig_d <= 1'b0;
    else     r_trig_d <= w_trig_s;
  end

  // Frame FSM with window counter, hit register and registered outputs
  always_ff @(posedge clk_250M) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wcnt       <= '0;
      r_hits       <= '0;
      r_ovf        <= 1'b0;
      r_tdc_start  <= 1'b0;
      r_rst_auto   <= 1'b0;
      r_hit_valid  <= 1'b0;
      r_rec        <= '0;
      r_frame_done <= 1'b0;
      r_frame_hits <= '0;
      r_frame_ovf  <= 1'b0;
    end else begin
      r_tdc_start  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_hits <= '0;
      r_frame_ovf  <= 1'b0;

      if (w_take) r_hit_valid <= 1'b0;

      // coarse time keeps running through the re-arm, pinned at the last bin
      if ((r_state inside {WINDOW, ARM, REARM}) && !w_win_end)
        r_wcnt <= r_wcnt + 1'b1;

      case (r_state)
        IDLE: begin
          if (io_bus.enable) begin
            r_state    <= CLEAR;
            r_rst_auto <= 1'b1;
            r_cnt      <= CNT_W'(DEAD_CYC - 1);
          end
        end
        CLEAR: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rst_auto  <= 1'b0;
            r_tdc_start <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          r_wcnt  <= '0;
          r_hits  <= '0;
          r_ovf   <= 1'b0;
          r_state <= WINDOW;
        end
        WINDOW: begin
          // a hit in the last bin wins over the window timeout
          if (w_hit) begin
            r_hits <= r_hits + 1'b1;
            if (!r_hit_valid || w_take) begin
              r_hit_valid <= 1'b1;
              r_rec       <= '{idx: r_hits, coarse: r_wcnt, intensity: io_bus.spad_int};
            end else begin
              r_ovf <= 1'b1;
            end
            r_state <= ARM;
          end else if (w_win_end) begin
            r_frame_done <= 1'b1;
            r_frame_hits <= r_hits;
            r_frame_ovf  <= r_ovf;
            r_state      <= DONE;
          end
        end
        ARM: begin
          if (!w_gate_s) begin
            r_rst_auto <= 1'b1;
            r_cnt      <= CNT_W'(DEAD_CYC - 1);
            r_state    <= REARM;
          end
        end
        REARM: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (r_rst_auto) begin
            r_rst_auto <= 1'b0;
          end else if (!w_trig_s) begin
            if ((r_hits == IDX_W'(MAX_HITS)) || w_win_end) begin
              r_frame_done <= 1'b1;
              r_frame_hits <= r_hits;
              r_frame_ovf  <= r_ovf;
              r_state      <= DONE;
            end else begin
              r_state <= WINDOW;
            end
          end
        end
        DONE: begin
          r_cnt   <= CNT_W'(GAP_CYC - 1);
          r_state <= GAP;
        end
        GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (io_bus.enable) begin
            r_rst_auto <= 1'b1;
            r_cnt      <= CNT_W'(DEAD_CYC - 1);
            r_state    <= CLEAR;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.tdc_start  = r_tdc_start;
  assign io_bus.rst_auto   = r_rst_auto;
  assign io_bus.hit_valid  = r_hit_valid;
  assign io_bus.hit_idx    = r_rec.idx;
  assign io_bus.hit_coarse = r_rec.coarse;
  assign io_bus.hit_int    = r_rec.intensity;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.frame_hits = r_frame_hits;
  assign io_bus.frame_ovf  = r_frame_ovf;

endmodule

// File: tb/tb_spad_tdc_sequencer.sv
// Directed bench for spad_tdc_sequencer. Cycle k after reset release is the
// cycle following the k-th rising edge; window cycle w of a frame whose
// tdc_start cycle is t0 is cycle t0+1+w.
module tb_spad_tdc_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;
  int   t0;
  int   t1;
  int   c;

  spad_tdc_sequencer_if bus ();

  spad_tdc_sequencer dut (
    .clk_250M (clk),
    .rst      (rst),
    .io_bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #2 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // SPAD model: trig stays high until the sequencer drives rst_auto
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.rst_auto === 1'b1) bus.trig = 1'b0;
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_tdc(input int budget, output int t);
    int n;
    n = 0;
    while (bus.tdc_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("tdc_start_seen", 32'(bus.tdc_start), 32'd1);
    t = cyc;
  endtask

  task automatic chk_rec(input string tag, input int idx, input int coarse, input int val);
    chk({tag, "_valid"},  32'(bus.hit_valid),  32'd1);
    chk({tag, "_idx"},    32'(bus.hit_idx),    32'(idx));
    chk({tag, "_coarse"}, 32'(bus.hit_coarse), 32'(coarse));
    chk({tag, "_int"},    32'(bus.hit_int),    32'(val));
  endtask

  task automatic chk_done(input string tag, input int hits, input int ovf);
    chk({tag, "_done"}, 32'(bus.frame_done), 32'd1);
    chk({tag, "_hits"}, 32'(bus.frame_hits), 32'(hits));
    chk({tag, "_ovf"},  32'(bus.frame_ovf),  32'(ovf));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tdc_start"},  32'(bus.tdc_start),  32'd0);
    chk({tag, "_rst_auto"},   32'(bus.rst_auto),   32'd0);
    chk({tag, "_hit_valid"},  32'(bus.hit_valid),  32'd0);
    chk({tag, "_hit_idx"},    32'(bus.hit_idx),    32'd0);
    chk({tag, "_hit_coarse"}, 32'(bus.hit_coarse), 32'd0);
    chk({tag, "_hit_int"},    32'(bus.hit_int),    32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_frame_hits"}, 32'(bus.frame_hits), 32'd0);
    chk({tag, "_frame_ovf"},  32'(bus.frame_ovf),  32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.enable    = 1'b0;
    bus.trig      = 1'b0;
    bus.time_gate = 1'b0;
    bus.spad_int  = 16'h0000;
    bus.hit_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk_all_zero("reset");
    bus.enable = 1'b1;
    tick();
    chk_all_zero("reset_en");

    // Frame 1: empty window
    rst = 1'b0;
    cyc = 0;
    goto(1);   chk("f1_clr_c1", 32'(bus.rst_auto), 32'd1);
               chk("f1_tdc_c1", 32'(bus.tdc_start), 32'd0);
    goto(4);   chk("f1_clr_c4", 32'(bus.rst_auto), 32'd1);
    goto(5);   chk("f1_clr_c5", 32'(bus.rst_auto), 32'd0);
               chk("f1_tdc_c5", 32'(bus.tdc_start), 32'd1);
    goto(6);   chk("f1_tdc_c6", 32'(bus.tdc_start), 32'd0);
    goto(517); chk("f1_done_early", 32'(bus.frame_done), 32'd0);
    goto(518); chk_done("f1", 0, 0);
    goto(519); chk("f1_done_pulse", 32'(bus.frame_done), 32'd0);
    goto(534); chk("f1_gap_end", 32'(bus.rst_auto), 32'd0);
    goto(535); chk("f2_clear", 32'(bus.rst_auto), 32'd1);

    // Frame 2: single hit with a 4-cycle time_gate pulse
    wait_tdc(50, t0);
    chk("f2_start_cycle", 32'(t0), 32'd539);
    goto(t0 + 101);
    bus.trig = 1'b1; bus.spad_int = 16'h0007; bus.time_gate = 1'b1;
    goto(t0 + 103); chk("f2_latency", 32'(bus.hit_valid), 32'd0);
    goto(t0 + 104); chk_rec("f2_rec", 0, 102, 7);
    goto(t0 + 105); bus.time_gate = 1'b0;
                    chk("f2_handshake", 32'(bus.hit_valid), 32'd0);
    goto(t0 + 107); chk("f2_arm_wait", 32'(bus.rst_auto), 32'd0);
    goto(t0 + 108); chk("f2_rearm_first", 32'(bus.rst_auto), 32'd1);
    goto(t0 + 111); chk("f2_rearm_last", 32'(bus.rst_auto), 32'd1);
    goto(t0 + 112); chk("f2_rearm_end", 32'(bus.rst_auto), 32'd0);
    goto(t0 + 513); chk_done("f2", 1, 0);

    // Frame 3: three hits end the frame early
    wait_tdc(600, t1);
    chk("frame_period", 32'(t1 - t0), 32'd534);
    t0 = t1;
    goto(t0 + 51);  bus.trig = 1'b1; bus.spad_int = 16'h0011;
    goto(t0 + 54);  chk_rec("f3_h0", 0, 52, 16'h0011);
    goto(t0 + 81);  bus.trig = 1'b1; bus.spad_int = 16'h0022;
    goto(t0 + 84);  chk_rec("f3_h1", 1, 82, 16'h0022);
    goto(t0 + 121); bus.trig = 1'b1; bus.spad_int = 16'h0033;
    goto(t0 + 124); chk_rec("f3_h2", 2, 122, 16'h0033);
    goto(t0 + 129); chk("f3_done_early", 32'(bus.frame_done), 32'd0);
    goto(t0 + 130); chk_done("f3", 3, 1'b0);

    // Frame 4: downstream stalled, second hit dropped
    wait_tdc(600, t0);
    bus.hit_ready = 1'b0;
    goto(t0 + 31);  bus.trig = 1'b1; bus.spad_int = 16'h1234;
    goto(t0 + 34);  chk_rec("f4_h0", 0, 32, 16'h1234);
    goto(t0 + 61);  bus.trig = 1'b1; bus.spad_int = 16'hBEEF;
    goto(t0 + 64);  chk_rec("f4_held", 0, 32, 16'h1234);
    goto(t0 + 513); chk_done("f4", 2, 1);
                    chk_rec("f4_held_end", 0, 32, 16'h1234);
    bus.hit_ready = 1'b1;
    goto(t0 + 514); chk("f4_drain", 32'(bus.hit_valid), 32'd0);

    // Frame 5: hit in the last window bin
    wait_tdc(600, t0);
    goto(t0 + 510); bus.trig = 1'b1; bus.spad_int = 16'h0555;
    goto(t0 + 512); chk("f5_latency", 32'(bus.hit_valid), 32'd0);
    goto(t0 + 513); chk_rec("f5_rec", 0, 511, 16'h0555);
                    chk("f5_no_timeout", 32'(bus.frame_done), 32'd0);
    goto(t0 + 514); chk("f5_rearm", 32'(bus.rst_auto), 32'd1);
    goto(t0 + 518); chk("f5_done_early", 32'(bus.frame_done), 32'd0);
    goto(t0 + 519); chk_done("f5", 1, 0);

    // Frame 6: reset during re-arm with a pending record
    wait_tdc(600, t0);
    bus.hit_ready = 1'b0;
    goto(t0 + 41);  bus.trig = 1'b1; bus.spad_int = 16'h0A0A;
    goto(t0 + 44);  chk_rec("f6_rec", 0, 42, 16'h0A0A);
    goto(t0 + 46);  chk("f6_in_rearm", 32'(bus.rst_auto), 32'd1);
    rst = 1'b1;
    goto(t0 + 47);  chk_all_zero("f6_rst");
    goto(t0 + 48);  chk("f6_rst_hold", 32'(bus.rst_auto), 32'd0);
    rst = 1'b0;
    bus.hit_ready = 1'b1;
    c = cyc;
    goto(c + 1); chk("f7_clr_c1", 32'(bus.rst_auto), 32'd1);
    goto(c + 4); chk("f7_clr_c4", 32'(bus.rst_auto), 32'd1);
    goto(c + 5); chk("f7_clr_c5", 32'(bus.rst_auto), 32'd0);
                 chk("f7_tdc_c5", 32'(bus.tdc_start), 32'd1);
                 chk("f7_no_stale_hit", 32'(bus.hit_valid), 32'd0);
    t0 = c + 5;

    // Frame 7: enable dropped mid-frame, frame completes then idles
    goto(t0 + 200); bus.enable = 1'b0;
    goto(t0 + 513); chk_done("f7", 0, 0);
    goto(t0 + 530); chk("f7_idle_no_clear", 32'(bus.rst_auto), 32'd0);
    goto(t0 + 540); chk("f7_idle_rst_auto", 32'(bus.rst_auto), 32'd0);
                    chk("f7_idle_tdc", 32'(bus.tdc_start), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
